// File: rtl/ping_pong_display_scanner_if.sv
// Display-side bundle: the count/direction inputs from the ping-pong
// counter and the multiplexed seven-segment drive outputs.
interface ping_pong_display_scanner_if;
  logic [3:0] value;
  logic       direction;
  logic       display_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  // Producer/observer side (counter plus the board that watches the display)
  modport master (
    output value,
    output direction,
    output display_en,
    input  an,
    input  seg,
    input  dp
  );

  // Scanner side
  modport slave (
    input  value,
    input  direction,
    input  display_en,
    output an,
    output seg,
    output dp
  );
endinterface

// File: rtl/ping_pong_display_scanner.sv
// Four-digit common-anode seven-segment scanner for the ping-pong counter.
// Digits 1:0 show the count in decimal (tens blanked below 10) and digits
// 3:2 show an arrow for the count direction. Inputs are snapshotted once
// per scan frame so a frame never mixes two values.
module ping_pong_display_scanner #(
  parameter int unsigned SCAN_CYCLES = 100000,
  parameter int unsigned CNT_W       = 20
) (
  input logic                         clk,
  input logic                         rst_n,
  ping_pong_display_scanner_if.slave  bus
);

  localparam logic [CNT_W-1:0] ScanLast  = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [6:0]       SegBlank  = 7'b1111111;
  localparam logic [6:0]       SegOne    = 7'b1111001;
  localparam logic [6:0]       SegUp     = 7'b1011100;
  localparam logic [6:0]       SegDown   = 7'b1100011;

  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [3:0]       snap_val_q, snap_val_d;
  logic             snap_dir_q, snap_dir_d;
  logic             primed_q, primed_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             scan_wrap;
  logic             snap_load;
  logic [3:0]       show_val;
  logic             show_dir;
  logic [3:0]       ones;

  // Active-low {g,f,e,d,c,b,a} decimal glyphs
  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Next-state for scan position, snapshot and registered display drive
  always_comb begin
    scan_wrap   = (scan_cnt_q == ScanLast);
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    digit_idx_d = scan_wrap ? digit_idx_q + 2'd1 : digit_idx_q;

    // Load once when priming, then only at the 3->0 frame boundary
    snap_load  = !primed_q || (scan_wrap && (digit_idx_q == 2'd3));
    snap_val_d = snap_load ? bus.value     : snap_val_q;
    snap_dir_d = snap_load ? bus.direction : snap_dir_q;
    primed_d   = 1'b1;

    // The priming clk already registers digit 0, so let it see the sample
    show_val = primed_q ? snap_val_q : bus.value;
    show_dir = primed_q ? snap_dir_q : bus.direction;
    ones     = (show_val >= 4'd10) ? show_val - 4'd10 : show_val;

    unique case (digit_idx_q)
      2'd0:    seg_d = dec7(ones);
      2'd1:    seg_d = (show_val >= 4'd10) ? SegOne : SegBlank;
      default: seg_d = show_dir ? SegUp : SegDown;
    endcase

    an_d = bus.display_en ? ~(4'b0001 << digit_idx_q) : 4'b1111;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      snap_val_q  <= 4'd0;
      snap_dir_q  <= 1'b1;
      primed_q    <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= SegBlank;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      snap_val_q  <= snap_val_d;
      snap_dir_q  <= snap_dir_d;
      primed_q    <= primed_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_ping_pong_display_scanner.sv
// Directed bench: a SCAN_CYCLES=4 scanner exercised frame by frame, plus a
// SCAN_CYCLES=1 scanner checked for per-clk digit stepping.
module tb_ping_pong_display_scanner;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ping_pong_display_scanner_if bus4 ();
  ping_pong_display_scanner_if bus1 ();

  ping_pong_display_scanner #(.SCAN_CYCLES(4), .CNT_W(20)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  ping_pong_display_scanner #(.SCAN_CYCLES(1), .CNT_W(20)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Hand-written expected glyphs
  function automatic logic [6:0] exp_seg(input int d, input logic [3:0] v, input logic dir);
    logic [6:0] dec [10];
    dec[0] = 7'b1000000; dec[1] = 7'b1111001; dec[2] = 7'b0100100; dec[3] = 7'b0110000;
    dec[4] = 7'b0011001; dec[5] = 7'b0010010; dec[6] = 7'b0000010; dec[7] = 7'b1111000;
    dec[8] = 7'b0000000; dec[9] = 7'b0010000;
    if (d == 0) return (v >= 10) ? dec[v - 10] : dec[v];
    if (d == 1) return (v >= 10) ? 7'b1111001 : 7'b1111111;
    return dir ? 7'b1011100 : 7'b1100011;
  endfunction

  function automatic logic [3:0] exp_an(input int d, input logic en);
    logic [3:0] tab [4];
    tab[0] = 4'b1110; tab[1] = 4'b1101; tab[2] = 4'b1011; tab[3] = 4'b0111;
    return en ? tab[d] : 4'b1111;
  endfunction

  // n clks of digit d on the SCAN_CYCLES=4 instance
  task automatic run_ticks(input string tag, input int d, input int n,
                           input logic [3:0] v, input logic dir, input logic en);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_an"}, {3'b000, bus4.an}, {3'b000, exp_an(d, en)});
      check({tag, "_seg"}, bus4.seg, exp_seg(d, v, dir));
    end
  endtask

  task automatic run_frame(input string tag, input logic [3:0] v, input logic dir);
    for (int d = 0; d < 4; d++) run_ticks(tag, d, 4, v, dir, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus4.value = 4'd7;  bus4.direction = 1'b1; bus4.display_en = 1'b1;
    bus1.value = 4'd15; bus1.direction = 1'b1; bus1.display_en = 1'b1;
    tick();
    tick();
    check("rst_an", {3'b000, bus4.an}, 7'b0001111);
    check("rst_seg", bus4.seg, 7'b1111111);
    check("rst_dp", {6'b0, bus4.dp}, 7'b0000001);

    // 1: value 7 up, first frame after release and a repeat
    rst_n = 1'b1;
    run_frame("t1_f0", 4'd7, 1'b1);
    // 2: switch to 13 down; next frame still 7, the one after shows 13
    bus4.value = 4'd13; bus4.direction = 1'b0;
    run_frame("t1_f1", 4'd7, 1'b1);
    run_frame("t2_13", 4'd13, 1'b0);
    check("dp_on", {6'b0, bus4.dp}, 7'b0000001);

    // 3: value 4, then change to 9 while digit_idx=1
    bus4.value = 4'd4; bus4.direction = 1'b1;
    run_frame("t3_old", 4'd13, 1'b0);
    run_frame("t3_4a", 4'd4, 1'b1);
    run_ticks("t3_4b", 0, 4, 4'd4, 1'b1, 1'b1);
    bus4.value = 4'd9;
    run_ticks("t3_4b", 1, 4, 4'd4, 1'b1, 1'b1);
    run_ticks("t3_4b", 2, 4, 4'd4, 1'b1, 1'b1);
    run_ticks("t3_4b", 3, 4, 4'd4, 1'b1, 1'b1);
    run_frame("t3_9", 4'd9, 1'b1);

    // 4: display off for 10 clks; seg keeps scanning, position undisturbed
    run_ticks("t4_pre", 0, 2, 4'd9, 1'b1, 1'b1);
    bus4.display_en = 1'b0;
    run_ticks("t4_off", 0, 2, 4'd9, 1'b1, 1'b0);
    run_ticks("t4_off", 1, 4, 4'd9, 1'b1, 1'b0);
    run_ticks("t4_off", 2, 4, 4'd9, 1'b1, 1'b0);
    bus4.display_en = 1'b1;
    run_ticks("t4_on", 3, 4, 4'd9, 1'b1, 1'b1);
    run_frame("t4_next", 4'd9, 1'b1);

    // 5: asynchronous reset at digit_idx=2, scan_cnt=2
    run_ticks("t5_pre", 0, 4, 4'd9, 1'b1, 1'b1);
    run_ticks("t5_pre", 1, 4, 4'd9, 1'b1, 1'b1);
    run_ticks("t5_pre", 2, 2, 4'd9, 1'b1, 1'b1);
    rst_n = 1'b0;
    bus4.value = 4'd2; bus4.direction = 1'b0;
    #2;
    check("t5_async_an", {3'b000, bus4.an}, 7'b0001111);
    check("t5_async_seg", bus4.seg, 7'b1111111);
    tick();
    check("t5_hold_an", {3'b000, bus4.an}, 7'b0001111);
    rst_n = 1'b1;
    run_frame("t5_after", 4'd2, 1'b0);

    // 6: SCAN_CYCLES=1 steps one digit per clk, one anode low at a time
    for (int f = 0; f < 2; f++) begin
      for (int d = 0; d < 4; d++) begin
        tick();
        check("t6_an", {3'b000, bus1.an}, {3'b000, exp_an(d, 1'b1)});
        check("t6_seg", bus1.seg, exp_seg(d, 4'd15, 1'b1));
        check("t6_onehot", 7'($countones(~bus1.an)), 7'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ping_pong_display_scanner.md
Name: ping_pong_display_scanner

Overview:
- Downstream display stage for the parameterized ping-pong counter.
- Consumes the counter's 4-bit count and direction bit.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display:
  - digits 1:0 show the count in decimal, with the tens digit blanked below 10;
  - digits 3:2 show an up or down arrow glyph for direction.
- Snapshots its inputs once per scan frame so the display never tears mid-frame.

Parameters:
SCAN_CYCLES, 100000, clk cycles each digit stays lit; legal range 1..2^20. Benches use 4.
CNT_W, 20, width of the internal scan counter; must hold SCAN_CYCLES-1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value  input  4  count from the ping-pong counter, 0..15
direction  input  1  1 = counting up, 0 = counting down
display_en  input  1  1 = drive digits; 0 = all anodes off, scanning continues
an  output  4  digit anodes, active-low; an[0] is the rightmost digit
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low; always 1 (off) after reset

Behaviour:
- Reset (asynchronous, rst_n=0):
  - scan_cnt=0, digit_idx=0.
  - snap_val=0, snap_dir=1, primed=0.
  - an=4'b1111, seg=7'b1111111, dp=1.
- Scan counter:
  - scan_cnt increments every clk.
  - When scan_cnt==SCAN_CYCLES-1 it wraps to 0 and digit_idx advances 0→1→2→3→0.
  - SCAN_CYCLES=1: digit_idx advances every clk.
- Snapshot:
  - snap_val/snap_dir load from value/direction on the first clk after reset release, when primed goes 0→1.
  - They also load on the clk where digit_idx wraps 3→0.
  - Between loads, input changes have no effect on the display.
- Digit content, selected by the digit_idx value the outputs are built from:
  - idx0: ones digit, snap_val mod 10.
  - idx1: tens digit, "1" if snap_val>=10, else blank (7'b1111111).
  - idx2 and idx3: arrow glyph.
    - snap_dir=1: up glyph, segments a,b,f lit = 7'b1011100.
    - snap_dir=0: down glyph, segments c,d,e lit = 7'b1100011.
- Decimal encoding, standard active-low table. Examples: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 5=7'b0010010, 8=7'b0000000, 9=7'b0010000.
- Output registers:
  - an and seg are registered and reflect digit_idx and the snapshot with exactly 1 clk latency.
  - an = ~(4'b0001 << digit_idx) when display_en=1, else 4'b1111.
  - seg keeps updating regardless of display_en.
- Simultaneous events:
  - A snapshot load and a digit_idx 3→0 wrap on the same clk: the idx0 output on the next clk uses the new snapshot.
  - display_en toggling takes effect on an after 1 clk and does not disturb scan_cnt, digit_idx or the snapshot.
- Reset mid-frame: immediate return to reset values regardless of scan position. The first frame after release uses the value sampled on the priming clk.
- Exactly one anode is low at any time when display_en=1; never two.

Test Plan:
1. SCAN_CYCLES=4, value=7, direction=1, display_en=1, release reset → an cycles 1110,1101,1011,0111, each held 4 clk. seg: 7'b1111000, 7'b1111111, 7'b1011100, 7'b1011100. Then repeats.
2. value=13, direction=0 → idx0 seg=7'b0110000, idx1 seg=7'b1111001, idx2/idx3 seg=7'b1100011.
3. Change value 4→9 while digit_idx=1 → digits keep showing 4 until the 3→0 wrap. The next idx0 digit shows 9 (7'b0010000).
4. display_en=0 for 10 clk mid-frame → an=4'b1111 one clk after the drop. After re-enable, scan position matches an uninterrupted run.
5. Assert rst_n=0 at digit_idx=2, scan_cnt=2 → an=4'b1111, seg=7'b1111111 immediately (asynchronous). After release, the first lit digit is idx0.
6. SCAN_CYCLES=1, value=15, direction=1 → an changes every clk. Display reads "1","5" and arrows; no cycle ever has two anodes low.
